ldpc_encoder: RTL

//  Serial (6,3) LDPC encoder. Sits directly downstream of generator_matrix and

---
 rtl/ldpc_encoder.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ldpc_encoder.sv
// -----------------------------------------------------------------------------
// ldpc_encoder
//
// Serial (6,3) LDPC encoder. It sits directly behind generator_matrix and
// builds the codeword cw = m0*g1 ^ m1*g2 ^ m2*g3, one message bit per clock.
// All arithmetic is over GF(2), so addition is XOR and there are no carries.
//
// On an accepted message the encoder takes a snapshot of the message and of
// all three generator rows. Changes on g1..g3 after the accept therefore do
// not affect the codeword in flight.
//
// State table
//   state | meaning
//   IDLE  | waiting for a message; msg_ready follows en
//   ACC   | folding one generator row per enabled clock into the accumulator
//   DONE  | finished codeword held on cw/cw_valid until out_ready
//
// Ports
//   clk        in   1        system clock, rising edge
//   rst        in   1        asynchronous reset, active-high
//   en         in   1        clock enable; 0 freezes all state and masks msg_ready
//   g1,g2,g3   in   6        generator rows ([2:0] identity, [5:3] parity)
//   msg_valid  in   1        message presented by upstream
//   msg        in   3        message bits; msg[0] selects g1, msg[1] g2, msg[2] g3
//   msg_ready  out  1        encoder accepts msg this cycle
//   cw_valid   out  1        cw holds a finished codeword
//   cw         out  6        codeword, registered
//   out_ready  in   1        consumer takes cw this cycle
//   busy       out  1        high in ACC or DONE
//   cw_count   out  COUNT_W  codewords handed off, wrapping
// -----------------------------------------------------------------------------
module ldpc_encoder #(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [5:0]         g1,
    input  logic [5:0]         g2,
    input  logic [5:0]         g3,
    input  logic               msg_valid,
    input  logic [2:0]         msg,
    output logic               msg_ready,
    output logic               cw_valid,
    output logic [5:0]         cw,
    input  logic               out_ready,
    output logic               busy,
    output logic [COUNT_W-1:0] cw_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         msg_q, msg_d;
    logic [5:0]         g1_q, g1_d;
    logic [5:0]         g2_q, g2_d;
    logic [5:0]         g3_q, g3_d;
    logic [5:0]         acc_q, acc_d;
    logic [1:0]         k_q, k_d;
    logic [5:0]         cw_q, cw_d;
    logic               cw_valid_q, cw_valid_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    logic               ready_int;
    logic               accept;
    logic               bit_sel;
    logic [5:0]         row_sel;
    logic [5:0]         acc_next;

    // Ready is combinational on out_ready so a DONE->ACC handoff can take a
    // new message on the same edge the old codeword leaves.
    assign ready_int = en && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign accept    = msg_valid && ready_int;

    // Row and message bit addressed by the bit counter.
    always_comb begin
        bit_sel = 1'b0;
        row_sel = 6'b000000;
        case (k_q)
            2'd0: begin
                bit_sel = msg_q[0];
                row_sel = g1_q;
            end
            2'd1: begin
                bit_sel = msg_q[1];
                row_sel = g2_q;
            end
            2'd2: begin
                bit_sel = msg_q[2];
                row_sel = g3_q;
            end
            default: begin
                bit_sel = 1'b0;
                row_sel = 6'b000000;
            end
        endcase
    end

    assign acc_next = acc_q ^ (bit_sel ? row_sel : 6'b000000);

    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        g1_d       = g1_q;
        g2_d       = g2_q;
        g3_d       = g3_q;
        acc_d      = acc_q;
        k_d        = k_q;
        cw_d       = cw_q;
        cw_valid_d = cw_valid_q;
        cnt_d      = cnt_q;

        if (en) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        msg_d   = msg;
                        g1_d    = g1;
                        g2_d    = g2;
                        g3_d    = g3;
                        acc_d   = 6'b000000;
                        k_d     = 2'd0;
                        state_d = ACC;
                    end
                end

                ACC: begin
                    acc_d = acc_next;
                    k_d   = k_q + 2'd1;
                    if (k_q == 2'd2) begin
                        cw_d       = acc_next;
                        cw_valid_d = 1'b1;
                        k_d        = 2'd0;
                        state_d    = DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        cnt_d      = cnt_q + {{(COUNT_W-1){1'b0}}, 1'b1};
                        cw_valid_d = 1'b0;
                        if (accept) begin
                            msg_d   = msg;
                            g1_d    = g1;
                            g2_d    = g2;
                            g3_d    = g3;
                            acc_d   = 6'b000000;
                            k_d     = 2'd0;
                            state_d = ACC;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end

                default: begin
                    state_d    = IDLE;
                    cw_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            msg_q      <= 3'b000;
            g1_q       <= 6'b000000;
            g2_q       <= 6'b000000;
            g3_q       <= 6'b000000;
            acc_q      <= 6'b000000;
            k_q        <= 2'd0;
            cw_q       <= 6'b000000;
            cw_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            g1_q       <= g1_d;
            g2_q       <= g2_d;
            g3_q       <= g3_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            cw_q       <= cw_d;
            cw_valid_q <= cw_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign msg_ready = ready_int;
    assign cw_valid  = cw_valid_q;
    assign cw        = cw_q;
    assign busy      = (state_q != IDLE);
    assign cw_count  = cnt_q;

endmodule
